user_input_encoder: RTL

Converts the three raw push buttons (INC, DEC, OK) into the one-hot, single-cycle `w_user_input` code consumed by the game controllers. It sits between the board pins and the play-mode controller. It provides synchronisation, debouncing, press-edge detection, priority encoding and auto-repeat for column selection. The controller compares its input by equality, so every output word must be zero or exactly one-hot.

---
 rtl/user_input_encoder_pkg.sv | 38 +++
 rtl/user_input_encoder_debouncer.sv | 49 ++++
 rtl/user_input_encoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/user_input_encoder_pkg.sv
// Shared codes, state types and sizing helpers for the user input encoder.
package user_input_encoder_pkg;

    localparam int unsigned BTN_W   = 3;
    localparam int unsigned CODE_W  = 4;

    // Bit positions of the buttons in i_btn_raw / o_btn_level
    localparam int unsigned BTN_INC = 0;
    localparam int unsigned BTN_DEC = 1;
    localparam int unsigned BTN_OK  = 2;

    // Codes shared with the game controllers; they compare by equality
    localparam logic [CODE_W-1:0] USER_INPUT_NONE = 4'b0000;
    localparam logic [CODE_W-1:0] USER_INPUT_INC  = 4'b0001;
    localparam logic [CODE_W-1:0] USER_INPUT_DEC  = 4'b0010;
    localparam logic [CODE_W-1:0] USER_INPUT_OK   = 4'b0100;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } repeat_state_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } repeat_dir_t;

    // Bits needed to hold 0..max_val without wrapping
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/user_input_encoder_debouncer.sv
// One button: 2-FF synchroniser, stability counter, stable level and press edge.
module btn_debouncer
    import user_input_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press_c
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise, then accept a level change only after DEBOUNCE_CYCLES differing cycles
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            sync_q1      <= 1'b0;
            sync_q2      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q1      <= i_raw;
            sync_q2      <= sync_q1;
            level_prev_q <= level_q;
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q2;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_level   = level_q;
    // High for exactly one cycle after the stable level rises
    assign o_press_c = level_q & ~level_prev_q;

endmodule

// File: rtl/user_input_encoder.sv
// Debounced buttons to one-hot single-cycle user input codes with INC/DEC auto-repeat.
module user_input_encoder
    import user_input_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 15000000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [2:0]  i_btn_raw,
    output logic [3:0]  o_user_input,
    output logic [2:0]  o_btn_level
);

    localparam int unsigned TMR_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

    logic [BTN_W-1:0]  level;
    logic [BTN_W-1:0]  press_c;

    repeat_state_t     state_q;
    repeat_dir_t       dir_q;
    logic [TMR_W-1:0]  timer_q;

    logic              rec_level_c;
    logic              opp_level_c;
    logic              abort_c;
    logic              repeat_c;
    logic              win_inc_c;
    logic              win_dec_c;
    logic [CODE_W-1:0] code_c;

    // One debouncer per button
    for (genvar g = 0; g < BTN_W; g++) begin : g_deb
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .w_clk     (w_clk),
            .w_rst     (w_rst),
            .i_raw     (i_btn_raw[g]),
            .o_level   (level[g]),
            .o_press_c (press_c[g])
        );
    end

    // Repeat abort: recorded button released, or the opposite direction is held
    always_comb begin
        rec_level_c = (dir_q == DIR_DEC) ? level[BTN_DEC] : level[BTN_INC];
        opp_level_c = (dir_q == DIR_DEC) ? level[BTN_INC] : level[BTN_DEC];
        abort_c     = ~rec_level_c | opp_level_c;
        repeat_c    = (state_q != R_IDLE) && !abort_c && (timer_q == '0);
    end

    // Priority encode: OK press > DEC press > INC press > repeat pulse; losers are dropped
    always_comb begin
        code_c    = USER_INPUT_NONE;
        win_inc_c = 1'b0;
        win_dec_c = 1'b0;
        if (press_c[BTN_OK]) begin
            code_c = USER_INPUT_OK;
        end else if (press_c[BTN_DEC]) begin
            code_c    = USER_INPUT_DEC;
            win_dec_c = 1'b1;
        end else if (press_c[BTN_INC]) begin
            code_c    = USER_INPUT_INC;
            win_inc_c = 1'b1;
        end else if (repeat_c) begin
            code_c = (dir_q == DIR_DEC) ? USER_INPUT_DEC : USER_INPUT_INC;
        end
    end

    // Auto-repeat FSM and output register; only a press that reached the output arms it
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q      <= R_IDLE;
            dir_q        <= DIR_INC;
            timer_q      <= '0;
            o_user_input <= USER_INPUT_NONE;
        end else begin
            o_user_input <= code_c;
            case (state_q)
                R_IDLE: begin
                    if (win_dec_c && !level[BTN_INC]) begin
                        state_q <= R_DELAY;
                        dir_q   <= DIR_DEC;
                        timer_q <= TMR_W'(REPEAT_DELAY);
                    end else if (win_inc_c && !level[BTN_DEC]) begin
                        state_q <= R_DELAY;
                        dir_q   <= DIR_INC;
                        timer_q <= TMR_W'(REPEAT_DELAY);
                    end
                end
                R_DELAY, R_REPEAT: begin
                    if (abort_c) begin
                        state_q <= R_IDLE;
                        timer_q <= '0;
                    end else if (timer_q == '0) begin
                        state_q <= R_REPEAT;
                        timer_q <= TMR_W'(REPEAT_PERIOD);
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign o_btn_level = level;

endmodule
